dsc_mul_param: RTL

Parametrised deterministic stochastic-computing (DSC) multiplier with early shutoff and a start/done handshake.
- Two unary stream generators (SNGs). Stream A cycles every enabled clock. Stream B advances once per full A period (clock division by enable, no derived clocks).
- The AND of the streams is counted into an exact binary product.
- Successor to the fixed 8-bit, 2-input multiplier. Used as the multiply primitive in the serial DSC datapath.

---
 rtl/dsc_pkg.sv | 25 ++
 rtl/dsc_mul_param_if.sv | 53 +++++
 rtl/dsc_unary_sng.sv | 47 ++++
 rtl/dsc_mul_param.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic-computing (DSC) multiplier.
//
// Contents:
//   dsc_state_e    - control state of the multiplier (idle / running)
//   stream_period  - length of one unary stream period for a given operand width (2^width)
//   prod_width     - width of the exact binary product for a given operand width (2*width)
package dsc_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } dsc_state_e;

  // Width used when nothing else is specified; matches the original fixed 8-bit multiplier.
  localparam int unsigned DefaultWidth = 8;

  function automatic int unsigned stream_period(input int unsigned width);
    return 32'd1 << width;
  endfunction

  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/dsc_mul_param_if.sv
// Operand / result bundle of the DSC multiplier.
//
// Signals:
//   en      - advance enable; low pauses a running multiply
//   start   - request a new multiply (taken only while idle)
//   a, b    - operands, WIDTH bits each, captured when start is taken
//   busy    - a multiply is in progress
//   done    - one-cycle pulse, z is valid from this cycle on
//   z       - product a*b, 2*WIDTH bits, held until the next accepted start
//   sn_out  - current product stream bit, debug only
//
// Modports:
//   master - the requester (drives en/start/a/b)
//   slave  - the multiplier
interface dsc_mul_param_if #(
  parameter int unsigned WIDTH = 8
);
  import dsc_pkg::*;

  localparam int unsigned ZW = prod_width(WIDTH);

  logic             en;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [ZW-1:0]    z;
  logic             sn_out;

  modport master (
    output en,
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  z,
    input  sn_out
  );

  modport slave (
    input  en,
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output z,
    output sn_out
  );

endinterface

// File: rtl/dsc_unary_sng.sv
// Unary stochastic number generator.
//
// An N-bit up-counter compared against a value produces a deterministic unary stream:
// within each 2^N period the stream is 1 for exactly 'val' cycles, starting at count 0.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the counter
//   clr   - synchronous clear (start of a new operation)
//   adv   - advance the counter by one this edge
//   val   - stream value; sn = (cnt < val)
//   cnt   - current count
//   sn    - current stream bit
//   wrap  - this edge advances the counter from its maximum back to zero
module dsc_unary_sng
  import dsc_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] cnt,
  output logic             sn,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (adv) begin
      // Natural modulo-2^N wrap from CntMax to zero.
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt  = cnt_q;
  assign sn   = (cnt_q < val);
  assign wrap = adv & (cnt_q == CntMax);

endmodule

// File: rtl/dsc_mul_param.sv
// Parametrised deterministic stochastic-computing multiplier with early shutoff.
//
// Stream A runs through a full 2^N period on every enabled cycle; stream B advances once per
// A period, so over 2^(2N) cycles every (cnt_a, cnt_b) pair is visited exactly once and the
// count of cycles where both streams are 1 is exactly a*b. With EARLY_STOP set, the run ends
// after B's last 1-period (b*2^N cycles) since no further product bits can be 1.
//
// Parameters:
//   WIDTH      - operand width N
//   EARLY_STOP - 1: stop once stream B is permanently zero; 0: always run 2^(2N) cycles
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset; aborts a run without a done pulse
//   bus  - slave side of dsc_mul_param_if (en, start, a, b, busy, done, z, sn_out)
module dsc_mul_param
  import dsc_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter bit          EARLY_STOP = 1'b1
) (
  input logic           clk,
  input logic           rst,
  dsc_mul_param_if.slave bus
);

  localparam int unsigned      ZW     = prod_width(WIDTH);
  localparam logic [WIDTH-1:0] CntMax = '1;

  dsc_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [ZW-1:0]    z_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] cnt_a;
  logic [WIDTH-1:0] cnt_b;
  logic             sn_a;
  logic             sn_b;
  logic             wrap_a;
  logic             wrap_b;

  logic             run;
  logic             accept;
  logic             adv_a;
  logic             adv_b;
  logic             early_hit;
  logic             last_edge;

  assign run    = (state_q == StRun);
  // Acceptance does not depend on en, so a paused requester can still launch an operation.
  assign accept = (state_q == StIdle) && bus.start;
  assign adv_a  = run && bus.en;
  // B steps only when A wraps: a clock divide by enable, no derived clock.
  assign adv_b  = wrap_a && bus.en;

  // Last A cycle of B's final 1-period; b_q is nonzero whenever this can be reached.
  assign early_hit = adv_a && (cnt_a == CntMax) && (cnt_b == (b_q - WIDTH'(1)));
  // Without early stop the run ends when both counters wrap together.
  assign last_edge = EARLY_STOP ? early_hit : wrap_b;

  dsc_unary_sng #(
    .WIDTH (WIDTH)
  ) u_sng_a (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .adv  (adv_a),
    .val  (a_q),
    .cnt  (cnt_a),
    .sn   (sn_a),
    .wrap (wrap_a)
  );

  dsc_unary_sng #(
    .WIDTH (WIDTH)
  ) u_sng_b (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .adv  (adv_b),
    .val  (b_q),
    .cnt  (cnt_b),
    .sn   (sn_b),
    .wrap (wrap_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
            z_q <= '0;
            if (EARLY_STOP && (bus.b == '0)) begin
              // Product is trivially zero: finish without ever going busy.
              done_q <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.en) begin
            z_q <= z_q + ZW'(sn_a & sn_b);
            if (last_edge) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.z      = z_q;
  assign bus.sn_out = busy_q & sn_a & sn_b;

endmodule
